// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared encodings for the stopwatch command front-end
package stopwatch_pkg;

    // Core status encodings (2'b11 is reserved and treated like idle)
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    // Lap capture field widths
    localparam int LAP_MIN_W = 8;
    localparam int LAP_SEC_W = 6;

    // Command sequencer states
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_ISSUE = 2'b01,
        CMD_WAIT  = 2'b10
    } cmd_state_t;

    // Command selected for the issue cycle
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_RESET = 2'b11
    } cmd_op_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, level debounce and press detect
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// rtl/stopwatch_cmd_ctrl.sv - button-driven command sequencer and lap display for the stopwatch core
module stopwatch_cmd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 8,
    parameter int LAP_CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_a_raw,
    input  logic                 btn_b_raw,
    input  logic [1:0]           status,
    input  logic [LAP_MIN_W-1:0] minutes,
    input  logic [LAP_SEC_W-1:0] seconds,
    output logic                 start,
    output logic                 stop,
    output logic                 reset,
    output logic [LAP_MIN_W-1:0] disp_minutes,
    output logic [LAP_SEC_W-1:0] disp_seconds,
    output logic                 lap_active,
    output logic [LAP_CNT_W-1:0] lap_count,
    output logic                 cmd_err,
    output logic                 busy
);

    localparam int              TO_W    = $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic w_level_a, w_press_a, w_level_b, w_press_b;
    logic w_evt_a, w_evt_b;

    cmd_state_t           r_state, w_state_nx;
    cmd_op_t              r_op, w_op_nx;
    logic [1:0]           r_expect, w_expect_nx;
    logic [TO_W-1:0]      r_tcnt, w_tcnt_nx;
    logic                 r_cmd_err, w_err_nx;
    logic                 r_lap_active, w_lap_act_nx;
    logic [LAP_CNT_W-1:0] r_lap_count, w_lap_cnt_nx;
    logic [LAP_MIN_W-1:0] r_lap_min, w_lap_min_nx;
    logic [LAP_SEC_W-1:0] r_lap_sec, w_lap_sec_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_a_raw),
        .level (w_level_a),
        .press (w_press_a)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_b_raw),
        .level (w_level_b),
        .press (w_press_b)
    );

    // A press always coincides with the debounced level going high; A has priority over B
    assign w_evt_a = w_press_a & w_level_a;
    assign w_evt_b = w_press_b & w_level_b & ~w_evt_a;

    // Next-state and lap bookkeeping; events outside CMD_IDLE are dropped
    always_comb begin
        w_state_nx   = r_state;
        w_op_nx      = r_op;
        w_expect_nx  = r_expect;
        w_tcnt_nx    = r_tcnt;
        w_err_nx     = r_cmd_err;
        w_lap_act_nx = r_lap_active;
        w_lap_cnt_nx = r_lap_count;
        w_lap_min_nx = r_lap_min;
        w_lap_sec_nx = r_lap_sec;
        case (r_state)
            CMD_IDLE: begin
                if (w_evt_a) begin
                    w_state_nx = CMD_ISSUE;
                    w_tcnt_nx  = '0;
                    if (status == ST_RUNNING) begin
                        w_op_nx     = OP_STOP;
                        w_expect_nx = ST_PAUSED;
                    end else begin
                        w_op_nx     = OP_START;
                        w_expect_nx = ST_RUNNING;
                    end
                end else if (w_evt_b) begin
                    if (status == ST_RUNNING) begin
                        if (!r_lap_active) begin
                            w_lap_min_nx = minutes;
                            w_lap_sec_nx = seconds;
                            w_lap_act_nx = 1'b1;
                            if (r_lap_count != '1) begin
                                w_lap_cnt_nx = r_lap_count + 1'b1;
                            end
                        end else begin
                            w_lap_act_nx = 1'b0;
                        end
                    end else if (status == ST_PAUSED) begin
                        w_state_nx   = CMD_ISSUE;
                        w_tcnt_nx    = '0;
                        w_op_nx      = OP_RESET;
                        w_expect_nx  = ST_IDLE;
                        w_lap_act_nx = 1'b0;
                        w_lap_cnt_nx = '0;
                        w_err_nx     = 1'b0;
                    end else begin
                        w_lap_act_nx = 1'b0;
                        w_lap_cnt_nx = '0;
                    end
                end
            end
            CMD_ISSUE: begin
                w_state_nx = CMD_WAIT;
                w_tcnt_nx  = '0;
            end
            CMD_WAIT: begin
                if (status == r_expect) begin
                    w_state_nx = CMD_IDLE;
                end else if (r_tcnt == TO_LAST) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = CMD_IDLE;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = CMD_IDLE;
            end
        endcase
    end

    // State, command context and lap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= CMD_IDLE;
            r_op         <= OP_NONE;
            r_expect     <= ST_IDLE;
            r_tcnt       <= '0;
            r_cmd_err    <= 1'b0;
            r_lap_active <= 1'b0;
            r_lap_count  <= '0;
            r_lap_min    <= '0;
            r_lap_sec    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_op         <= w_op_nx;
            r_expect     <= w_expect_nx;
            r_tcnt       <= w_tcnt_nx;
            r_cmd_err    <= w_err_nx;
            r_lap_active <= w_lap_act_nx;
            r_lap_count  <= w_lap_cnt_nx;
            r_lap_min    <= w_lap_min_nx;
            r_lap_sec    <= w_lap_sec_nx;
        end
    end

    assign start      = (r_state == CMD_ISSUE) && (r_op == OP_START);
    assign stop       = (r_state == CMD_ISSUE) && (r_op == OP_STOP);
    assign reset      = (r_state == CMD_ISSUE) && (r_op == OP_RESET);
    assign busy       = (r_state != CMD_IDLE);
    assign cmd_err    = r_cmd_err;
    assign lap_active = r_lap_active;
    assign lap_count  = r_lap_count;

    // Display mux is blanked while reset is asserted so every output reads 0
    assign disp_minutes = !rst_n ? '0 : (r_lap_active ? r_lap_min : minutes);
    assign disp_seconds = !rst_n ? '0 : (r_lap_active ? r_lap_sec : seconds);

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// tb/tb_stopwatch_cmd_ctrl.sv - scoreboard bench for the stopwatch command front-end
module tb_stopwatch_cmd_ctrl;
    import stopwatch_pkg::*;

    localparam int DEB = 4;
    localparam int ACK = 8;
    localparam int LCW = 4;

    localparam logic [2:0] C_START = 3'b100;
    localparam logic [2:0] C_STOP  = 3'b010;
    localparam logic [2:0] C_RESET = 3'b001;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           btn_a_raw, btn_b_raw;
    logic [1:0]     status;
    logic [7:0]     minutes;
    logic [5:0]     seconds;
    logic           start, stop, reset;
    logic [7:0]     disp_minutes;
    logic [5:0]     disp_seconds;
    logic           lap_active;
    logic [LCW-1:0] lap_count;
    logic           cmd_err, busy;

    typedef struct {
        logic [2:0] code;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       sb[$];
    int         n_checks    = 0;
    int         n_fail      = 0;
    int         cyc         = 0;
    int         busy_cycles = 0;
    bit         ack_en      = 1'b1;
    int         ack_cnt     = 0;
    logic [1:0] ack_status  = 2'b00;

    stopwatch_cmd_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .ACK_TIMEOUT     (ACK),
        .LAP_CNT_W       (LCW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_a_raw    (btn_a_raw),
        .btn_b_raw    (btn_b_raw),
        .status       (status),
        .minutes      (minutes),
        .seconds      (seconds),
        .start        (start),
        .stop         (stop),
        .reset        (reset),
        .disp_minutes (disp_minutes),
        .disp_seconds (disp_seconds),
        .lap_active   (lap_active),
        .lap_count    (lap_count),
        .cmd_err      (cmd_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Expected pulse lat cycles after now, with one cycle of sampling-phase slack
    task automatic expect_cmd(input logic [2:0] code, input int lat);
        sb.push_back('{code: code, lo: cyc + lat - 1, hi: cyc + lat + 1});
    endtask

    // Advance n cycles: scoreboard any command pulse, then run the core model
    task automatic step(input int n);
        logic [2:0] obs;
        exp_t       e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            obs = {start, stop, reset};
            if (obs != 3'b000) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_unexpected: got %b at cycle %0d, required no command", obs, cyc);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e.code || cyc < e.lo || cyc > e.hi) begin
                        n_fail++;
                        $display("FAIL cmd_pulse: got %b at cycle %0d, required %b in cycles %0d..%0d",
                                 obs, cyc, e.code, e.lo, e.hi);
                    end
                end
            end
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) status = ack_status;
            end
            if (ack_en && obs != 3'b000) begin
                ack_cnt    = 2;
                ack_status = start ? ST_RUNNING : (stop ? ST_PAUSED : ST_IDLE);
            end
        end
    endtask

    task automatic press(input bit a, input bit b, input int hold);
        btn_a_raw = a;
        btn_b_raw = b;
        step(hold);
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        step(12);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        minutes = 8'd7;
        seconds = 6'd5;
        step(3);
        n_checks++;
        if ({start, stop, reset, busy, cmd_err, lap_active, lap_count, disp_minutes, disp_seconds} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got s%b p%b r%b busy%b err%b lap%b cnt%0d disp %0d:%0d, required all 0",
                     start, stop, reset, busy, cmd_err, lap_active, lap_count, disp_minutes, disp_seconds);
        end
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (disp_minutes !== 8'd7 || disp_seconds !== 6'd5) begin
            n_fail++;
            $display("FAIL live_display: got %0d:%0d, required 7:5", disp_minutes, disp_seconds);
        end
    endtask

    task automatic test_start;
        busy_cycles = 0;
        status      = ST_IDLE;
        expect_cmd(C_START, 7);
        press(1'b1, 1'b0, 10);
        n_checks++;
        if (busy_cycles != 3) begin
            n_fail++;
            $display("FAIL start_busy_len: got %0d cycles, required 3", busy_cycles);
        end
        n_checks++;
        if (sb.size() != 0 || status !== ST_RUNNING) begin
            n_fail++;
            $display("FAIL start_done: got %0d pending, status %b, required 0 pending, status 01", sb.size(), status);
        end
    endtask

    task automatic test_glitch;
        busy_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            btn_a_raw = ~btn_a_raw;
            step(1);
        end
        btn_a_raw = 1'b0;
        step(20);
        n_checks++;
        if (busy_cycles != 0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %0d busy cycles, required 0", busy_cycles);
        end
    endtask

    task automatic test_lap;
        status  = ST_RUNNING;
        minutes = 8'd3;
        seconds = 6'd42;
        press(1'b0, 1'b1, 10);
        minutes = 8'd3;
        seconds = 6'd45;
        step(1);
        n_checks++;
        if (lap_active !== 1'b1 || lap_count !== 4'd1 || disp_minutes !== 8'd3 || disp_seconds !== 6'd42) begin
            n_fail++;
            $display("FAIL lap_capture: got lap%b cnt%0d disp %0d:%0d, required lap1 cnt1 disp 3:42",
                     lap_active, lap_count, disp_minutes, disp_seconds);
        end
        press(1'b0, 1'b1, 10);
        n_checks++;
        if (lap_active !== 1'b0 || lap_count !== 4'd1 || disp_minutes !== 8'd3 || disp_seconds !== 6'd45) begin
            n_fail++;
            $display("FAIL lap_release: got lap%b cnt%0d disp %0d:%0d, required lap0 cnt1 disp 3:45",
                     lap_active, lap_count, disp_minutes, disp_seconds);
        end
    endtask

    task automatic test_reset_cmd;
        bit seen;
        for (int i = 0; i < 7; i++) press(1'b0, 1'b1, 10);
        n_checks++;
        if (lap_count !== 4'd5 || lap_active !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_count_5: got cnt%0d lap%b, required cnt5 lap1", lap_count, lap_active);
        end
        status      = ST_PAUSED;
        busy_cycles = 0;
        seen        = 1'b0;
        expect_cmd(C_RESET, 7);
        btn_b_raw = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1);
            if (reset) begin
                seen = 1'b1;
                n_checks++;
                if (lap_count !== 4'd0 || lap_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_lap_clear: got cnt%0d lap%b, required cnt0 lap0", lap_count, lap_active);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_timeout: got no reset pulse within 12 cycles, required one");
        end
        step(10);
        btn_b_raw = 1'b0;
        step(12);
        n_checks++;
        if (busy_cycles != 3 || busy !== 1'b0 || status !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_ack: got busy_cycles %0d busy%b status %b, required 3, 0, 00",
                     busy_cycles, busy, status);
        end
    endtask

    task automatic test_back_to_back;
        status      = ST_RUNNING;
        busy_cycles = 0;
        expect_cmd(C_STOP, 7);
        press(1'b1, 1'b1, 10);
        n_checks++;
        if (lap_active !== 1'b0 || lap_count !== 4'd0 || status !== ST_PAUSED || busy_cycles != 3) begin
            n_fail++;
            $display("FAIL both_a_wins: got lap%b cnt%0d status %b busy_cycles %0d, required lap0 cnt0 10 3",
                     lap_active, lap_count, status, busy_cycles);
        end
        expect_cmd(C_START, 7);
        btn_a_raw = 1'b1;
        step(2);
        btn_b_raw = 1'b1;
        step(8);
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        step(12);
        n_checks++;
        if (sb.size() != 0 || lap_active !== 1'b0 || status !== ST_RUNNING) begin
            n_fail++;
            $display("FAIL b_during_wait: got %0d pending lap%b status %b, required 0 pending lap0 status 01",
                     sb.size(), lap_active, status);
        end
    endtask

    task automatic test_timeout;
        status      = ST_IDLE;
        ack_en      = 1'b0;
        busy_cycles = 0;
        expect_cmd(C_START, 7);
        press(1'b1, 1'b0, 10);
        n_checks++;
        if (cmd_err !== 1'b1 || busy_cycles != ACK + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_timeout: got err%b busy_cycles %0d busy%b, required err1 %0d busy0",
                     cmd_err, busy_cycles, busy, ACK + 1);
        end
        status = ST_PAUSED;
        ack_en = 1'b1;
        expect_cmd(C_RESET, 7);
        press(1'b0, 1'b1, 10);
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err%b, required 0", cmd_err);
        end
        ack_en  = 1'b0;
        status  = ST_IDLE;
        minutes = 8'd9;
        expect_cmd(C_START, 7);
        btn_a_raw = 1'b1;
        step(10);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait: got busy%b, required 1", busy);
        end
        btn_a_raw = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if ({start, stop, reset, busy, cmd_err, lap_active, lap_count, disp_minutes, disp_seconds} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got s%b p%b r%b busy%b err%b lap%b cnt%0d disp %0d:%0d, required all 0",
                     start, stop, reset, busy, cmd_err, lap_active, lap_count, disp_minutes, disp_seconds);
        end
        step(3);
        rst_n = 1'b1;
        step(20);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending commands, required 0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        status    = ST_IDLE;
        minutes   = 8'd0;
        seconds   = 6'd0;
        test_reset();
        test_start();
        test_glitch();
        test_lap();
        test_reset_cmd();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_cmd_ctrl.md
Name: stopwatch_cmd_ctrl

Overview:
- Front-end controller that sequences the stopwatch core from two raw push-buttons.
- Synchronises and debounces both buttons, then arbitrates the resulting press events.
- Issues single-cycle start/stop/reset command pulses and waits for the core's status to acknowledge each one.
- Provides lap-freeze display capture and drives the display-side minutes/seconds.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a level change (min 2).
- ACK_TIMEOUT, 8, cycles to wait for the status acknowledge before flagging cmd_err (min 2).
- LAP_CNT_W, 4, width of lap_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_a_raw  in  1  start/stop button, asynchronous, active-high
- btn_b_raw  in  1  lap/reset button, asynchronous, active-high
- status  in  2  core status: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 reserved
- minutes  in  8  live minutes from core
- seconds  in  6  live seconds from core
- start  out  1  one-cycle start command to core
- stop  out  1  one-cycle stop command to core
- reset  out  1  one-cycle reset command to core
- disp_minutes  out  8  displayed minutes
- disp_seconds  out  6  displayed seconds
- lap_active  out  1  display frozen on captured lap
- lap_count  out  LAP_CNT_W  laps taken since last reset, saturating
- cmd_err  out  1  sticky acknowledge-timeout flag
- busy  out  1  command FSM not in CMD_IDLE

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; lap registers 0; synchronisers and debounce counters 0; FSM in CMD_IDLE. The debounced level resets to 0, so a button held through reset yields no event.
- Button path, per button:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from the current level. Any sample equal to the current level clears the counter.
  - A press event is a one-cycle pulse on a 0->1 change of the debounced level. Release generates nothing.
- Arbitration:
  - If both press events occur in the same cycle, A wins and B is dropped.
  - Events arriving while busy=1 are dropped, never queued.
- Command FSM states: CMD_IDLE, CMD_ISSUE, CMD_WAIT.
  - CMD_IDLE, on A event: status RUNNING -> issue stop, expect PAUSED; otherwise -> issue start, expect RUNNING.
  - CMD_IDLE, on B event:
    - status RUNNING, lap_active=0: capture minutes/seconds into the lap registers in that cycle; lap_active<=1; lap_count increments, saturating at all-ones. No command; stay in CMD_IDLE.
    - status RUNNING, lap_active=1: lap_active<=0. No command.
    - status PAUSED: issue reset, expect IDLE; clear lap_active and lap_count in the same cycle.
    - status IDLE or reserved: clear lap_active and lap_count. No command.
  - CMD_ISSUE: lasts exactly one cycle. The selected command output is high for that cycle only, in the cycle after the event. Next state is CMD_WAIT with the timeout counter at 0.
  - CMD_WAIT:
    - status == expected -> CMD_IDLE.
    - Otherwise the counter increments; at ACK_TIMEOUT-1 the FSM sets cmd_err and goes to CMD_IDLE.
    - Total wait never exceeds ACK_TIMEOUT cycles.
- cmd_err clears only on rst_n or when a reset command is issued.
- busy is high in CMD_ISSUE and CMD_WAIT.
- At most one of start/stop/reset is high in any cycle.
- Display: disp = lap_active ? lap registers : live inputs, combinational. The mux adds no latency.
- lap_active survives stop/start; it is cleared only by a B event or a reset command.
- End-to-end latency: raw edge -> command pulse = 2 sync + DEBOUNCE_CYCLES + 1 cycles, ±1 for sampling phase.

Decomposition:
- Shared package stopwatch_pkg:
  - status encodings ST_IDLE, ST_RUNNING, ST_PAUSED.
  - command FSM state enum.
  - lap field widths (8 minutes, 6 seconds).
- Sub-module btn_debounce:
  - parameter DEBOUNCE_CYCLES.
  - ports clk, rst_n, raw, level, press.
  - instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, core model acknowledges 1 cycle after the command):
- A held 10 cycles with status IDLE -> exactly one start pulse, 7±1 cycles after the raw edge; busy high 3 cycles; stop and reset stay 0.
- A toggling every cycle for 3 cycles, then low -> no press event, no command.
- Status RUNNING, minutes=3, seconds=42, then B press; core continues to 3:45 -> lap_active=1, disp shows 3:42, lap_count=1. Second B press -> disp follows live 3:45, lap_active=0.
- Status PAUSED, lap_count=5, B press -> one reset pulse; lap_count=0 and lap_active=0 in the same cycle as the reset pulse; FSM returns to CMD_IDLE when status reads IDLE.
- Both press events in the same cycle with status RUNNING -> stop issued; lap not captured. B press during CMD_WAIT -> dropped.
- Core model never acknowledges start -> cmd_err=1 after 8 cycles in CMD_WAIT; later reset command -> cmd_err=0. rst_n asserted mid-CMD_WAIT -> all outputs 0 immediately.
